sevenseg_mux: RTL and testbench



---
 rtl/sevenseg_mux.sv | 162 ++++++++++++++++
 tb/tb_sevenseg_mux.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_mux.sv
// Multiplexed N-digit common-anode seven-segment driver with tear-free frame updates.
// Define SEVENSEG_LZB_EN to enable leading-zero blanking.
module sevenseg_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    load_i,
    output logic                    pend_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLK = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         disp_q, disp_d;
    logic [NUM_DIGITS-1:0] ddp_q, ddp_d;
    logic [DW-1:0]         pdig_q, pdig_d;
    logic [NUM_DIGITS-1:0] pdp_q, pdp_d;
    logic                  pend_q, pend_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dpo_q, dpo_d;

    logic                  tick;
    logic                  frame;
    logic [3:0]            nib;
    logic                  blank;
    logic                  dpsel;
    logic [NUM_DIGITS-1:0] blank_mask;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign tick  = (cnt_q == CNT_MAX);
    assign frame = tick && (idx_q == IDX_MAX);

    always_comb begin
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        idx_d  = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
        disp_d = disp_q;
        ddp_d  = ddp_q;
        pdig_d = pdig_q;
        pdp_d  = pdp_q;
        pend_d = pend_q;
        // A load landing on the boundary bypasses the pending register.
        if (load_i && frame) begin
            disp_d = digits_i;
            ddp_d  = dp_i;
            pend_d = 1'b0;
        end else if (load_i) begin
            pdig_d = digits_i;
            pdp_d  = dp_i;
            pend_d = 1'b1;
        end else if (frame && pend_q) begin
            disp_d = pdig_q;
            ddp_d  = pdp_q;
            pend_d = 1'b0;
        end
    end

`ifdef SEVENSEG_LZB_EN
    always_comb begin : lzb
        logic lz;
        lz         = 1'b1;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz            = lz && (disp_q[i*4 +: 4] == 4'h0);
            blank_mask[i] = lz;
        end
    end
`else
    assign blank_mask = '0;
`endif

    always_comb begin
        nib   = '0;
        blank = 1'b0;
        dpsel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib   = disp_q[i*4 +: 4];
                blank = blank_mask[i];
                dpsel = ddp_q[i];
            end
        end
    end

    always_comb begin
        an_d  = (cnt_q < CNT_BLK) ? '1 : ~(NUM_DIGITS'(1) << idx_q);
        seg_d = blank ? 7'b1111111 : decode(nib);
        dpo_d = ~dpsel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            disp_q <= '0;
            ddp_q  <= '0;
            pdig_q <= '0;
            pdp_q  <= '0;
            pend_q <= 1'b0;
            an_q   <= '1;
            seg_q  <= 7'b1111111;
            dpo_q  <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            disp_q <= disp_d;
            ddp_q  <= ddp_d;
            pdig_q <= pdig_d;
            pdp_q  <= pdp_d;
            pend_q <= pend_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dpo_q  <= dpo_d;
        end
    end

    assign pend_o = pend_q;
    assign an_o   = an_q;
    assign seg_o  = seg_q;
    assign dp_o   = dpo_q;

endmodule

// File: tb/tb_sevenseg_mux.sv
// Scoreboard bench for sevenseg_mux: expected scan frames are queued per load.
// Define SEVENSEG_LZB_EN to check the leading-zero blanking build.
module tb_sevenseg_mux;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits_i;
    logic [3:0]  dp_i;
    logic        load_i;
    logic        pend_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;

    sevenseg_mux #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(4),
        .BLANK_CYC  (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .digits_i(digits_i),
        .dp_i    (dp_i),
        .load_i  (load_i),
        .pend_o  (pend_o),
        .seg_o   (seg_o),
        .dp_o    (dp_o),
        .an_o    (an_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        logic [6:0] t[16];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        return t[v];
    endfunction

    // One frame is 4 slots of 4 cycles: 1 blank cycle then 3 lit cycles.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] p);
        logic [3:0] blk;
        logic       lz;
        exp_t       e;
        blk = '0;
`ifdef SEVENSEG_LZB_EN
        lz = 1'b1;
        for (int k = 3; k >= 1; k--) begin
            lz     = lz && (d[k*4 +: 4] == 4'h0);
            blk[k] = lz;
        end
`else
        lz = 1'b0;
`endif
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                e.an  = (c == 0) ? 4'b1111 : ~(4'b0001 << s);
                e.seg = blk[s] ? 7'b1111111 : ref_seg(d[s*4 +: 4]);
                e.dp  = ~p[s];
                sb.push_back(e);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p);
        digits_i = d;
        dp_i     = p;
        load_i   = 1'b1;
        step();
        load_i   = 1'b0;
    endtask

    task automatic check_frame(input string name);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            step();
            total++;
            if (sb.size() == 0) begin
                $display("FAIL %s: scoreboard empty at cycle %0d", name, cyc);
            end else begin
                e = sb.pop_front();
                if ({an_o, seg_o, dp_o} !== {e.an, e.seg, e.dp})
                    $display("FAIL %s[%0d]: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                             name, i, an_o, seg_o, dp_o, e.an, e.seg, e.dp);
                else
                    passed++;
            end
        end
    endtask

    task automatic check_pend(input string name, input logic want);
        total++;
        if (pend_o !== want)
            $display("FAIL %s: pend_o=%b, want %b", name, pend_o, want);
        else
            passed++;
    endtask

    task automatic check_reset_outs(input string name);
        total++;
        if ({an_o, seg_o, dp_o, pend_o} !== {4'b1111, 7'b1111111, 1'b1, 1'b0})
            $display("FAIL %s: an=%b seg=%b dp=%b pend=%b, want 1111 1111111 1 0",
                     name, an_o, seg_o, dp_o, pend_o);
        else
            passed++;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outs("reset_hold");
        release_reset();
        push_frame(16'h0000, 4'b0000);
        check_frame("reset_frame");
    endtask

    task automatic test_load();
        goto(20);
        load(16'h1234, 4'b0010);
        check_pend("load_pend_rise", 1'b1);
        goto(31);
        check_pend("load_pend_hold", 1'b1);
        goto(32);
        check_pend("load_pend_clear", 1'b0);
        push_frame(16'h1234, 4'b0010);
        check_frame("load_1234");
    endtask

    task automatic test_slot_timing();
        int blanks;
        int lows;
        blanks = 0;
        lows   = 0;
        goto(48);
        for (int i = 0; i < 16; i++) begin
            step();
            if (an_o == 4'b1111) blanks++;
            if ($countones(~an_o) == 1) lows++;
        end
        total++;
        if (blanks !== 4 || lows !== 12)
            $display("FAIL slot_timing: blanks=%0d lows=%0d, want 4 and 12", blanks, lows);
        else
            passed++;
    endtask

    task automatic test_hex();
        goto(64);
        load(16'hABCD, 4'b0000);
        goto(80);
        push_frame(16'hABCD, 4'b0000);
        check_frame("hex_abcd");
    endtask

    task automatic test_back_to_back();
        goto(96);
        load(16'h1111, 4'b0000);
        goto(99);
        load(16'h2222, 4'b0000);
        goto(112);
        check_pend("b2b_pend_clear", 1'b0);
        push_frame(16'h2222, 4'b0000);
        check_frame("last_load_wins");
        goto(143);
        load(16'h9876, 4'b1000);
        check_pend("boundary_load_pend", 1'b0);
        push_frame(16'h9876, 4'b1000);
        check_frame("boundary_load");
    endtask

    task automatic test_lzb();
        goto(160);
        load(16'h0070, 4'b0000);
        goto(176);
        push_frame(16'h0070, 4'b0000);
        check_frame("lzb_0070");
    endtask

    task automatic test_reset_mid();
        goto(192);
        load(16'hFFFF, 4'b1111);
        goto(200);
        check_pend("mid_pend", 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outs("reset_async");
        repeat (2) @(negedge clk);
        release_reset();
        push_frame(16'h0000, 4'b0000);
        push_frame(16'h0000, 4'b0000);
        check_frame("post_reset_f0");
        check_frame("post_reset_f1");
        check_pend("post_reset_pend", 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        digits_i = '0;
        dp_i     = '0;
        load_i   = 1'b0;
        test_reset();
        test_load();
        test_slot_timing();
        test_hex();
        test_back_to_back();
        test_lzb();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
